// File: rtl/types_pkg.sv
// Shared types for the acquisition sequencer: sampling modes, sequencer states
// and the per-mode limit on captured events.
package types_pkg;

    typedef enum logic [1:0] {
        MODE_SAMPLE1 = 2'd0,
        MODE_SAMPLE2 = 2'd1,
        MODE_SAMPLE4 = 2'd2
    } smode_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ACQ,
        STOP_WAIT,
        STOP,
        READOUT,
        SCAN,
        DONE
    } seq_state_t;

    // Number of events a channel can hold in the given mode; unknown encodings get 1.
    function automatic logic [2:0] max_events(input smode_t m);
        case (m)
            MODE_SAMPLE1: return 3'd4;
            MODE_SAMPLE2: return 3'd2;
            MODE_SAMPLE4: return 3'd1;
            default:      return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/stop_sync.sv
// Brings the per-channel STOP_REQUEST levels into the clk domain through two
// flops each and merges them into a single stop indication.
module stop_sync #(
    parameter int NUM_CH = 8
) (
    input  logic              clk,
    input  logic              RSTB,
    input  logic [NUM_CH-1:0] stop_request_i,
    output logic              stop_any_o
);

    logic [NUM_CH-1:0] meta_q;
    logic [NUM_CH-1:0] sync_q;

    // NOTE: sequential state is written with <= only, so every flop samples the
    // pre-edge value of its source and the two stages really are two stages.
    always_ff @(posedge clk or negedge RSTB) begin
        if (!RSTB) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= stop_request_i;
            sync_q <= meta_q;
        end
    end

    assign stop_any_o = |sync_q;

endmodule

// File: rtl/ch_acq_sequencer.sv
// Chip-level acquisition sequencer: broadcasts start/stop/readout to all channels,
// then walks every channel's captured events out over a valid/ready handshake.
module ch_acq_sequencer
    import types_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DLY_W  = 8,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                RSTB,
    input  logic                arm,
    input  smode_t              mode,
    input  logic [DLY_W-1:0]    stop_delay,
    input  logic                force_stop,
    input  logic [NUM_CH-1:0]   stop_request,
    input  logic [NUM_CH*3-1:0] trigger_cnt,
    output logic                inst_start,
    output logic                inst_stop,
    output logic                inst_readout,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [CH_W-1:0]     rd_ch,
    output logic [2:0]          rd_blk,
    output logic                busy,
    output logic                done
);

    seq_state_t              state_q, state_d;
    smode_t                  mode_q, mode_d;
    logic [DLY_W-1:0]        dly_q, dly_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [2:0]              blk_q, blk_d;
    logic [NUM_CH-1:0][2:0]  n_q, n_d;
    logic [NUM_CH-1:0][2:0]  clamp_n;
    logic [2:0]              ev_limit;
    logic                    stop_any;

    logic inst_start_q, inst_start_d;
    logic inst_stop_q, inst_stop_d;
    logic inst_readout_q, inst_readout_d;
    logic rd_valid_q, rd_valid_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    stop_sync #(.NUM_CH(NUM_CH)) u_stop_sync (
        .clk            (clk),
        .RSTB           (RSTB),
        .stop_request_i (stop_request),
        .stop_any_o     (stop_any)
    );

    // Clamping at snapshot time makes late trigger increments after the stop harmless.
    assign ev_limit = max_events(mode_q);

    always_comb begin
        clamp_n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            clamp_n[i] = (trigger_cnt[3*i +: 3] > ev_limit) ? ev_limit : trigger_cnt[3*i +: 3];
        end
    end

    // NOTE: the snapshot array is small and its contents must not survive a
    // reset into the next acquisition, so it is cleared with the other flops.
    always_ff @(posedge clk or negedge RSTB) begin
        if (!RSTB) begin
            state_q        <= IDLE;
            mode_q         <= MODE_SAMPLE1;
            dly_q          <= '0;
            ch_q           <= '0;
            blk_q          <= '0;
            n_q            <= '0;
            inst_start_q   <= 1'b0;
            inst_stop_q    <= 1'b0;
            inst_readout_q <= 1'b0;
            rd_valid_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            dly_q          <= dly_d;
            ch_q           <= ch_d;
            blk_q          <= blk_d;
            n_q            <= n_d;
            inst_start_q   <= inst_start_d;
            inst_stop_q    <= inst_stop_d;
            inst_readout_q <= inst_readout_d;
            rd_valid_q     <= rd_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // NOTE: every signal gets its hold value first so no path through the case
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dly_d   = dly_q;
        ch_d    = ch_q;
        blk_d   = blk_q;
        n_d     = n_q;
        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = START;
                    mode_d  = mode;
                end
            end
            START: state_d = ACQ;
            ACQ: begin
                if (force_stop) begin
                    state_d = STOP;
                end else if (stop_any) begin
                    state_d = STOP_WAIT;
                    dly_d   = stop_delay;
                end
            end
            STOP_WAIT: begin
                if (force_stop || dly_q == '0) state_d = STOP;
                else                           dly_d   = dly_q - 1'b1;
            end
            STOP: begin
                state_d = READOUT;
                n_d     = clamp_n;
            end
            READOUT: begin
                state_d = SCAN;
                ch_d    = '0;
                blk_d   = '0;
            end
            SCAN: begin
                // A channel is finished once its block index reaches its snapshot count.
                if (blk_q == n_q[ch_q]) begin
                    blk_d = '0;
                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                        state_d = DONE;
                        ch_d    = '0;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end else if (rd_valid_q && rd_ready) begin
                    blk_d = blk_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        inst_start_d   = (state_d == START);
        inst_stop_d    = (state_d == STOP);
        inst_readout_d = (state_d == READOUT);
        rd_valid_d     = (state_d == SCAN) && (blk_d != n_d[ch_d]);
        busy_d         = (state_d != IDLE);
        done_d         = (state_d == DONE);
    end

    assign inst_start   = inst_start_q;
    assign inst_stop    = inst_stop_q;
    assign inst_readout = inst_readout_q;
    assign rd_valid     = rd_valid_q;
    assign rd_ch        = ch_q;
    assign rd_blk       = blk_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_ch_acq_sequencer.sv
// Self-checking bench for ch_acq_sequencer: table of acquisitions plus hand-written
// force-stop, ignored-input and reset sequences, with a read scoreboard.
module tb_ch_acq_sequencer;
    import types_pkg::*;

    localparam int NUM_CH = 8;
    localparam int DLY_W  = 8;
    localparam int CH_W   = 3;

    logic                clk = 1'b0;
    logic                RSTB = 1'b0;
    logic                arm = 1'b0;
    smode_t              mode = MODE_SAMPLE1;
    logic [DLY_W-1:0]    stop_delay = '0;
    logic                force_stop = 1'b0;
    logic [NUM_CH-1:0]   stop_request = '0;
    logic [NUM_CH*3-1:0] trigger_cnt = '0;
    logic                rd_ready = 1'b0;
    logic                inst_start, inst_stop, inst_readout, rd_valid, busy, done;
    logic [CH_W-1:0]     rd_ch;
    logic [2:0]          rd_blk;

    int errors = 0;
    int checks = 0;
    int reads_seen = 0;

    typedef struct {
        int ch;
        int blk;
    } rd_t;
    rd_t exp_q[$];

    typedef struct {
        smode_t      m;
        logic [23:0] tc;
        int          stop_ch;
        int          dly;
        int          bp;
    } vec_t;
    vec_t vecs[6];

    ch_acq_sequencer #(.NUM_CH(NUM_CH), .DLY_W(DLY_W)) dut (
        .clk          (clk),
        .RSTB         (RSTB),
        .arm          (arm),
        .mode         (mode),
        .stop_delay   (stop_delay),
        .force_stop   (force_stop),
        .stop_request (stop_request),
        .trigger_cnt  (trigger_cnt),
        .inst_start   (inst_start),
        .inst_stop    (inst_stop),
        .inst_readout (inst_readout),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_ch        (rd_ch),
        .rd_blk       (rd_blk),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int max_ev(input smode_t m);
        case (m)
            MODE_SAMPLE1: return 4;
            MODE_SAMPLE2: return 2;
            MODE_SAMPLE4: return 1;
            default:      return 1;
        endcase
    endfunction

    // Pushes the reads the serializer must see, in channel/block order.
    task automatic push_expected(input smode_t m, input logic [23:0] tc, output int total);
        total = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            int cnt;
            int n;
            cnt = int'(tc[3*c +: 3]);
            n   = (cnt < max_ev(m)) ? cnt : max_ev(m);
            for (int b = 0; b < n; b++) exp_q.push_back('{c, b});
            total += n;
        end
    endtask

    // which: 0 = inst_stop, 1 = done, 2 = rd_valid. n = negedge count, -1 on timeout.
    task automatic wait_sig(input int which, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if ((which == 0 && inst_stop) || (which == 1 && done) || (which == 2 && rd_valid)) begin
                n = k;
                break;
            end
        end
    endtask

    // Scoreboard: every accepted read must match the head of the expected queue.
    always @(negedge clk) begin
        if (rd_valid && rd_ready) begin
            reads_seen++;
            if (exp_q.size() == 0) begin
                check("sb_extra_read_ch", int'(rd_ch), -1);
            end else begin
                rd_t e;
                e = exp_q.pop_front();
                check("sb_ch", int'(rd_ch), e.ch);
                check("sb_blk", int'(rd_blk), e.blk);
            end
        end
    end

    always @(negedge clk) begin
        if (inst_start || inst_stop || inst_readout)
            check("pulse_exclusive", int'(inst_start) + int'(inst_stop) + int'(inst_readout), 1);
    end

    task automatic start_acq(input string tag);
        reads_seen = 0;
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
        @(negedge clk);
        check({tag, "_start"}, int'(inst_start), 1);
        check({tag, "_busy"}, int'(busy), 1);
        @(negedge clk);
        check({tag, "_start_1cyc"}, int'(inst_start), 0);
    endtask

    // From the inst_stop cycle through done; scan length only checked with ready held high.
    task automatic finish_acq(input string tag, input int total, input int bp);
        int n;
        int ch0;
        int b0;
        @(negedge clk);
        check({tag, "_readout"}, int'(inst_readout), 1);
        stop_request = '0;
        force_stop   = 1'b0;
        if (bp != 0) begin
            wait_sig(2, 40, n);
            check({tag, "_bp_valid_seen"}, int'(n > 0), 1);
            ch0 = int'(rd_ch);
            b0  = int'(rd_blk);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                check({tag, "_bp_hold"}, int'(rd_valid) * 100 + int'(rd_ch) * 8 + int'(rd_blk), 100 + ch0 * 8 + b0);
            end
            @(posedge clk); #1 rd_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check({tag, "_bp_advance"}, int'(rd_ch) * 8 + int'(rd_blk), ch0 * 8 + b0 + 1);
            wait_sig(1, 200, n);
            check({tag, "_done_seen"}, int'(n > 0), 1);
        end else begin
            wait_sig(1, 200, n);
            // READOUT->SCAN edge, then (n[ch]+1) cycles per channel, then DONE.
            check({tag, "_scan_len"}, n, total + NUM_CH + 1);
        end
        check({tag, "_reads"}, reads_seen, total);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        @(negedge clk);
        check({tag, "_idle"}, int'(busy) * 2 + int'(done), 0);
    endtask

    task automatic run_acq(input vec_t v, input string tag);
        int total;
        int n;
        mode        = v.m;
        trigger_cnt = v.tc;
        stop_delay  = DLY_W'(v.dly);
        rd_ready    = (v.bp == 0);
        push_expected(v.m, v.tc, total);
        start_acq(tag);
        @(posedge clk); #1 stop_request[v.stop_ch] = 1'b1;
        wait_sig(0, v.dly + 20, n);
        // Two synchronizer flops, one ACQ detect cycle, then stop_delay+1 in STOP_WAIT.
        check({tag, "_stop_latency"}, n, v.dly + 5);
        finish_acq(tag, total, v.bp);
    endtask

    initial begin
        int total;
        int n;
        int starts;
        vec_t v;

        vecs[0] = '{MODE_SAMPLE1, 24'd2 << 6, 2, 3, 0};
        vecs[1] = '{MODE_SAMPLE2, 24'd4, 0, 0, 0};
        vecs[2] = '{MODE_SAMPLE4, 24'd3 << 15, 5, 1, 0};
        vecs[3] = '{MODE_SAMPLE1, (24'd7) | (24'd4 << 9) | (24'd3 << 12) | (24'd1 << 21), 7, 5, 0};
        vecs[4] = '{smode_t'(2'd3), (24'd5 << 3) | (24'd2 << 18), 3, 0, 0};
        vecs[5] = '{MODE_SAMPLE1, (24'd2) | (24'd1 << 12), 4, 2, 1};

        repeat (3) @(negedge clk);
        check("reset_outputs", {inst_start, inst_stop, inst_readout, rd_valid, busy, done, rd_ch, rd_blk}, 0);
        @(posedge clk); #1 RSTB = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {inst_start, inst_stop, inst_readout, rd_valid, busy, done, rd_ch, rd_blk}, 0);

        for (int i = 0; i < 6; i++) run_acq(vecs[i], $sformatf("vec%0d", i));

        // force_stop during a long stop delay; arm during ACQ; mode changed after arm.
        mode        = MODE_SAMPLE1;
        trigger_cnt = 24'd3 << 3;
        stop_delay  = 8'd200;
        rd_ready    = 1'b1;
        push_expected(MODE_SAMPLE1, 24'd3 << 3, total);
        start_acq("fs");
        mode = MODE_SAMPLE4;
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
        starts = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            starts += int'(inst_start);
        end
        check("ign_arm_no_start", starts, 0);
        check("ign_arm_busy", int'(busy), 1);
        @(posedge clk); #1 stop_request[4] = 1'b1;
        repeat (10) @(negedge clk);
        check("fs_still_waiting", int'(inst_stop), 0);
        @(posedge clk); #1 force_stop = 1'b1;
        wait_sig(0, 4, n);
        check("fs_stop_latency", n, 2);
        finish_acq("fs", total, 0);

        // force_stop in IDLE does nothing.
        @(posedge clk); #1 force_stop = 1'b1;
        @(posedge clk); #1 force_stop = 1'b0;
        starts = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            starts += int'(busy) + int'(inst_start) + int'(inst_stop);
        end
        check("ign_force_idle", starts, 0);

        // Reset in the middle of SCAN, then a clean acquisition.
        mode        = MODE_SAMPLE1;
        trigger_cnt = (24'd3 << 18) | (24'd4 << 21);
        stop_delay  = 8'd0;
        rd_ready    = 1'b0;
        push_expected(MODE_SAMPLE1, trigger_cnt, total);
        start_acq("rst");
        @(posedge clk); #1 stop_request[0] = 1'b1;
        wait_sig(0, 20, n);
        check("rst_stop_seen", int'(n > 0), 1);
        stop_request = '0;
        wait_sig(2, 40, n);
        check("rst_scan_ch6", int'(rd_ch), 6);
        #2 RSTB = 1'b0;
        #1 check("rst_async_clear", {inst_start, inst_stop, inst_readout, rd_valid, busy, done, rd_ch, rd_blk}, 0);
        exp_q.delete();
        rd_ready = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 RSTB = 1'b1;
        v = '{MODE_SAMPLE1, 24'd1 << 9, 1, 2, 0};
        run_acq(v, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
